cell_fetch_pipe: RTL and testbench

// - Upstream stage of the tile/sprite renderer. Maps VGA scan position (hCount/vCount) to board cell coordinates using incremental counters, with no divide-by-30.
// - Reads the apparent cell state from the board RAM.
// - Presents x_coord/y_coord/cell_apparent to the renderer, aligned with a delayed copy of hCount/vCount.

---
 rtl/cell_fetch_pipe.sv | 235 +++++++++++++++++++++++
 tb/tb_cell_fetch_pipe.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_fetch_pipe.sv
// ----------------------------------------------------------------------------
// cell_fetch_pipe
//
// Upstream stage of the tile/sprite renderer. Converts the VGA scan position
// into board cell coordinates with incremental sub-pixel/cell counters (no
// divide by CELL_PX), fetches the apparent cell state from the board RAM and
// presents it together with a delayed copy of the scan position.
//
// Pipeline (all state advances only on pix_en):
//   stage 0  update counters, register rd_addr = {y_cell, x_cell}, scan
//            position and the in-grid flag of the sampled pixel.
//   stage 1  on the next pix_en, capture rd_data with the stage-0 coords,
//            hCount/vCount and in_grid. A pixel sampled on one pix_en pulse
//            is therefore visible on the outputs after the following pulse.
//
// Ports
//   masterclk       system clock, rising edge
//   rst_n           asynchronous active-low reset
//   pix_en          one-cycle pixel strobe, pulses at least 2 cycles apart
//   hCount/vCount   scan column/row, valid with pix_en
//   rd_addr         board RAM address {y_cell, x_cell}
//   rd_data         board RAM apparent state, valid one cycle after rd_addr
//   hCount_o/_o     scan position aligned with the cell outputs
//   x_coord/y_coord cell column/row of the output pixel
//   cell_apparent   apparent state (10000 cover, 10001 flag, 0xxxx count,
//                   11111 mine)
//   in_grid         output pixel is inside the grid and counters are synced;
//                   when low, x_coord/y_coord/cell_apparent hold stale values
//
// Build option
//   CELL_SUB_OUT_EN adds x_sub_o/y_sub_o, the pixel offset inside the cell,
//                   aligned with x_coord/y_coord. Without it the sub counters
//                   stay internal.
// ----------------------------------------------------------------------------
module cell_fetch_pipe #(
  parameter int unsigned GRID_X0 = 224,
  parameter int unsigned GRID_Y0 = 36,
  parameter int unsigned CELL_PX = 30,
  parameter int unsigned COLS    = 16,
  parameter int unsigned ROWS    = 16
) (
  input  logic       masterclk,
  input  logic       rst_n,
  input  logic       pix_en,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  output logic [7:0] rd_addr,
  input  logic [4:0] rd_data,
  output logic [9:0] hCount_o,
  output logic [9:0] vCount_o,
  output logic [3:0] x_coord,
  output logic [3:0] y_coord,
  output logic [4:0] cell_apparent,
  output logic       in_grid
`ifdef CELL_SUB_OUT_EN
  ,
  output logic [4:0] x_sub_o,
  output logic [4:0] y_sub_o
`endif
);

  localparam int unsigned XEnd = GRID_X0 + COLS * CELL_PX;
  localparam int unsigned YEnd = GRID_Y0 + ROWS * CELL_PX;

  localparam logic [9:0] X0        = 10'(GRID_X0);
  localparam logic [9:0] Y0        = 10'(GRID_Y0);
  localparam logic [9:0] XLim      = 10'(XEnd);
  localparam logic [9:0] YLim      = 10'(YEnd);
  localparam logic [4:0] SubLast   = 5'(CELL_PX - 1);
  localparam logic [3:0] XCellLast = 4'(COLS - 1);
  localparam logic [3:0] YCellLast = 4'(ROWS - 1);

  // Geometry must fit the 10-bit scan counters and the fixed port widths.
  if (XEnd > 1023) begin : g_bad_x_extent
    $error("cell_fetch_pipe: GRID_X0 + COLS*CELL_PX exceeds 1023");
  end
  if (YEnd > 1023) begin : g_bad_y_extent
    $error("cell_fetch_pipe: GRID_Y0 + ROWS*CELL_PX exceeds 1023");
  end
  if (COLS > 16 || ROWS > 16 || CELL_PX > 32 || CELL_PX < 1) begin : g_bad_geometry
    $error("cell_fetch_pipe: COLS/ROWS must be <= 16 and CELL_PX in 1..32");
  end

  // --------------------------------------------------------------------------
  // Stage 0: scan decode and incremental counters
  // --------------------------------------------------------------------------
  logic       h_in;
  logic       v_in;
  logic       line_start;
  logic       frame_start;
  logic       pix_in_grid;

  logic [4:0] x_sub_q, x_sub_d;
  logic [3:0] x_cell_q, x_cell_d;
  logic [4:0] y_sub_q, y_sub_d;
  logic [3:0] y_cell_q, y_cell_d;
  logic       sync_q, sync_d;

  logic [7:0] rd_addr_q;
  logic [9:0] s0_h_q;
  logic [9:0] s0_v_q;
  logic       s0_in_q;

  always_comb begin
    h_in        = (hCount >= X0) && (hCount < XLim);
    v_in        = (vCount >= Y0) && (vCount < YLim);
    line_start  = (hCount == X0);
    frame_start = line_start && (vCount == Y0);
  end

  // Horizontal counters. Line start wins over a coincident sub wrap.
  always_comb begin
    x_sub_d  = x_sub_q;
    x_cell_d = x_cell_q;
    if (line_start) begin
      x_sub_d  = '0;
      x_cell_d = '0;
    end else if (h_in) begin
      if (x_sub_q != SubLast) begin
        x_sub_d = x_sub_q + 5'd1;
      end else if (x_cell_q != XCellLast) begin
        x_sub_d  = '0;
        x_cell_d = x_cell_q + 4'd1;
      end
      // Last pixel of the last column: hold rather than wrap.
    end
  end

  // Vertical counters step once per line, at the line-start pixel.
  always_comb begin
    y_sub_d  = y_sub_q;
    y_cell_d = y_cell_q;
    if (frame_start) begin
      y_sub_d  = '0;
      y_cell_d = '0;
    end else if (line_start && v_in) begin
      if (y_sub_q != SubLast) begin
        y_sub_d = y_sub_q + 5'd1;
      end else if (y_cell_q != YCellLast) begin
        y_sub_d  = '0;
        y_cell_d = y_cell_q + 4'd1;
      end
    end
  end

  // Counters are only trusted once a frame origin has been seen since reset.
  always_comb begin
    sync_d      = sync_q | frame_start;
    pix_in_grid = h_in & v_in & sync_d;
  end

  always_ff @(posedge masterclk or negedge rst_n) begin
    if (!rst_n) begin
      x_sub_q   <= '0;
      x_cell_q  <= '0;
      y_sub_q   <= '0;
      y_cell_q  <= '0;
      sync_q    <= 1'b0;
      rd_addr_q <= '0;
      s0_h_q    <= '0;
      s0_v_q    <= '0;
      s0_in_q   <= 1'b0;
    end else if (pix_en) begin
      x_sub_q   <= x_sub_d;
      x_cell_q  <= x_cell_d;
      y_sub_q   <= y_sub_d;
      y_cell_q  <= y_cell_d;
      sync_q    <= sync_d;
      rd_addr_q <= {y_cell_d, x_cell_d};
      s0_h_q    <= hCount;
      s0_v_q    <= vCount;
      s0_in_q   <= pix_in_grid;
    end
  end

  assign rd_addr = rd_addr_q;

  // --------------------------------------------------------------------------
  // Stage 1: capture RAM data alongside the stage-0 pixel
  // --------------------------------------------------------------------------
  logic [9:0] h_out_q;
  logic [9:0] v_out_q;
  logic [3:0] x_coord_q;
  logic [3:0] y_coord_q;
  logic [4:0] apparent_q;
  logic       in_grid_q;

  always_ff @(posedge masterclk or negedge rst_n) begin
    if (!rst_n) begin
      h_out_q    <= '0;
      v_out_q    <= '0;
      x_coord_q  <= '0;
      y_coord_q  <= '0;
      apparent_q <= '0;
      in_grid_q  <= 1'b0;
    end else if (pix_en) begin
      h_out_q   <= s0_h_q;
      v_out_q   <= s0_v_q;
      in_grid_q <= s0_in_q;
      // Cell data only moves for in-grid pixels; otherwise keep the last one.
      if (s0_in_q) begin
        x_coord_q  <= rd_addr_q[3:0];
        y_coord_q  <= rd_addr_q[7:4];
        apparent_q <= rd_data;
      end
    end
  end

  assign hCount_o      = h_out_q;
  assign vCount_o      = v_out_q;
  assign x_coord       = x_coord_q;
  assign y_coord       = y_coord_q;
  assign cell_apparent = apparent_q;
  assign in_grid       = in_grid_q;

`ifdef CELL_SUB_OUT_EN
  // Sub offsets follow the same hold rule as x_coord/y_coord.
  logic [4:0] x_sub_out_q;
  logic [4:0] y_sub_out_q;

  always_ff @(posedge masterclk or negedge rst_n) begin
    if (!rst_n) begin
      x_sub_out_q <= '0;
      y_sub_out_q <= '0;
    end else if (pix_en && s0_in_q) begin
      x_sub_out_q <= x_sub_q;
      y_sub_out_q <= y_sub_q;
    end
  end

  assign x_sub_o = x_sub_out_q;
  assign y_sub_o = y_sub_out_q;
`endif

endmodule

// File: tb/tb_cell_fetch_pipe.sv
// ----------------------------------------------------------------------------
// Testbench for cell_fetch_pipe with the default geometry (224,36,30,16,16).
// Pixels are strobed every 4 masterclk cycles; outputs are sampled on the
// falling edge. The board RAM returns {3'b0,addr[1:0]}+1 one cycle after
// rd_addr changes.
// ----------------------------------------------------------------------------
module tb_cell_fetch_pipe;

  logic       masterclk = 1'b0;
  logic       rst_n     = 1'b0;
  logic       pix_en    = 1'b0;
  logic [9:0] hCount    = '0;
  logic [9:0] vCount    = '0;
  logic [7:0] rd_addr;
  logic [4:0] rd_data   = '0;
  logic [9:0] hCount_o;
  logic [9:0] vCount_o;
  logic [3:0] x_coord;
  logic [3:0] y_coord;
  logic [4:0] cell_apparent;
  logic       in_grid;
`ifdef CELL_SUB_OUT_EN
  logic [4:0] x_sub_o;
  logic [4:0] y_sub_o;
`endif

  int checks = 0;
  int errors = 0;

  cell_fetch_pipe dut (
    .masterclk     (masterclk),
    .rst_n         (rst_n),
    .pix_en        (pix_en),
    .hCount        (hCount),
    .vCount        (vCount),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .hCount_o      (hCount_o),
    .vCount_o      (vCount_o),
    .x_coord       (x_coord),
    .y_coord       (y_coord),
    .cell_apparent (cell_apparent),
`ifdef CELL_SUB_OUT_EN
    .x_sub_o       (x_sub_o),
    .y_sub_o       (y_sub_o),
`endif
    .in_grid       (in_grid)
  );

  always #5 masterclk = ~masterclk;

  // Board RAM model: one-cycle read latency.
  always @(posedge masterclk) rd_data <= 5'({3'b000, rd_addr[1:0]}) + 5'd1;

  // Reference cell address for an in-range scan position (x saturates at 15).
  function automatic logic [7:0] cell_of(input int h, input int v);
    int xc;
    int yc;
    xc = (h - 224) / 30;
    yc = (v - 36) / 30;
    if (xc > 15) xc = 15;
    if (yc > 15) yc = 15;
    return {4'(yc), 4'(xc)};
  endfunction

  function automatic logic [4:0] ram_of(input logic [7:0] a);
    return 5'({3'b000, a[1:0]}) + 5'd1;
  endfunction

  // One pixel strobe; returns on a falling edge with the results settled.
  task automatic pixel(input int h, input int v);
    @(negedge masterclk);
    hCount = 10'(h);
    vCount = 10'(v);
    pix_en = 1'b1;
    @(negedge masterclk);
    pix_en = 1'b0;
    repeat (2) @(negedge masterclk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge masterclk);
    pixel(224, 36);
    pixel(225, 36);
    checks++;
    if (rd_addr !== 8'h00 || hCount_o !== 10'd0 || vCount_o !== 10'd0 || x_coord !== 4'd0 ||
        y_coord !== 4'd0 || cell_apparent !== 5'd0 || in_grid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got a=%h h=%0d v=%0d x=%0d y=%0d c=%h g=%b want all zero",
               rd_addr, hCount_o, vCount_o, x_coord, y_coord, cell_apparent, in_grid);
    end
    // Release in the middle of a frame.
    @(negedge masterclk);
    rst_n = 1'b1;
    pixel(300, 200);
    pixel(301, 200);
    pixel(224, 201);
    pixel(225, 201);
    checks++;
    if (in_grid !== 1'b0 || hCount_o !== 10'd224 || vCount_o !== 10'd201) begin
      errors++;
      $display("FAIL unsynced_row: got g=%b h=%0d v=%0d want g=0 h=224 v=201",
               in_grid, hCount_o, vCount_o);
    end
    pixel(224, 36);
    checks++;
    if (in_grid !== 1'b0) begin
      errors++;
      $display("FAIL origin_not_yet_out: got g=%b want 0", in_grid);
    end
    pixel(225, 36);
    checks++;
    if (in_grid !== 1'b1 || hCount_o !== 10'd224 || vCount_o !== 10'd36 || x_coord !== 4'd0 ||
        y_coord !== 4'd0 || cell_apparent !== 5'd1) begin
      errors++;
      $display("FAIL origin_out: got g=%b h=%0d v=%0d x=%0d y=%0d c=%h want g=1 h=224 v=36 x=0 y=0 c=01",
               in_grid, hCount_o, vCount_o, x_coord, y_coord, cell_apparent);
    end
  endtask

  task automatic test_row36();
    logic [7:0] ea;
    logic [7:0] pa;
    pa = 8'h00;
    for (int h = 224; h <= 704; h++) begin
      pixel(h, 36);
      ea = cell_of(h, 36);
      checks++;
      if (rd_addr !== ea) begin
        errors++;
        $display("FAIL row36_rd_addr h=%0d: got %h want %h", h, rd_addr, ea);
      end
      if (h > 224) begin
        checks++;
        if (hCount_o !== 10'(h - 1) || vCount_o !== 10'd36 || in_grid !== 1'b1 ||
            x_coord !== pa[3:0] || y_coord !== pa[7:4] || cell_apparent !== ram_of(pa)) begin
          errors++;
          $display("FAIL row36_out h=%0d: got h=%0d v=%0d g=%b x=%0d y=%0d c=%h want h=%0d v=36 g=1 x=%0d y=%0d c=%h",
                   h, hCount_o, vCount_o, in_grid, x_coord, y_coord, cell_apparent,
                   h - 1, pa[3:0], pa[7:4], ram_of(pa));
        end
      end
      pa = ea;
    end
    pixel(705, 36);
    checks++;
    if (in_grid !== 1'b0 || hCount_o !== 10'd704 || x_coord !== 4'd15 ||
        cell_apparent !== 5'd4 || rd_addr !== 8'h0F) begin
      errors++;
      $display("FAIL row36_edge: got g=%b h=%0d x=%0d c=%h a=%h want g=0 h=704 x=15 c=04 a=0f",
               in_grid, hCount_o, x_coord, cell_apparent, rd_addr);
    end
  endtask

  task automatic test_row_advance();
    for (int v = 37; v <= 66; v++) begin
      pixel(224, v);
      checks++;
      if (rd_addr !== cell_of(224, v)) begin
        errors++;
        $display("FAIL row_adv_rd_addr v=%0d: got %h want %h", v, rd_addr, cell_of(224, v));
      end
    end
    pixel(225, 66);
    checks++;
    if (y_coord !== 4'd1 || x_coord !== 4'd0 || hCount_o !== 10'd224 || vCount_o !== 10'd66 ||
        cell_apparent !== 5'd1 || in_grid !== 1'b1) begin
      errors++;
      $display("FAIL row66_out: got x=%0d y=%0d h=%0d v=%0d c=%h g=%b want x=0 y=1 h=224 v=66 c=01 g=1",
               x_coord, y_coord, hCount_o, vCount_o, cell_apparent, in_grid);
    end
  endtask

  task automatic test_corner();
    for (int v = 67; v <= 515; v++) begin
      pixel(224, v);
      checks++;
      if (rd_addr !== cell_of(224, v)) begin
        errors++;
        $display("FAIL col0_rd_addr v=%0d: got %h want %h", v, rd_addr, cell_of(224, v));
      end
    end
    for (int h = 225; h <= 703; h++) begin
      pixel(h, 515);
      checks++;
      if (rd_addr !== cell_of(h, 515)) begin
        errors++;
        $display("FAIL row515_rd_addr h=%0d: got %h want %h", h, rd_addr, cell_of(h, 515));
      end
    end
    pixel(704, 515);
    checks++;
    if (x_coord !== 4'd15 || y_coord !== 4'd15 || hCount_o !== 10'd703 || vCount_o !== 10'd515 ||
        cell_apparent !== 5'd4 || in_grid !== 1'b1 || rd_addr !== 8'hFF) begin
      errors++;
      $display("FAIL corner_out: got x=%0d y=%0d h=%0d v=%0d c=%h g=%b a=%h want x=15 y=15 h=703 v=515 c=04 g=1 a=ff",
               x_coord, y_coord, hCount_o, vCount_o, cell_apparent, in_grid, rd_addr);
    end
    pixel(224, 516);
    checks++;
    if (rd_addr !== 8'hF0) begin
      errors++;
      $display("FAIL below_grid_rd_addr: got %h want f0", rd_addr);
    end
    pixel(225, 516);
    checks++;
    if (in_grid !== 1'b0 || hCount_o !== 10'd224 || vCount_o !== 10'd516 ||
        x_coord !== 4'd15 || y_coord !== 4'd15 || cell_apparent !== 5'd4) begin
      errors++;
      $display("FAIL below_grid_out: got g=%b h=%0d v=%0d x=%0d y=%0d c=%h want g=0 h=224 v=516 x=15 y=15 c=04",
               in_grid, hCount_o, vCount_o, x_coord, y_coord, cell_apparent);
    end
    pixel(224, 1000);
    checks++;
    if (rd_addr !== 8'hF0) begin
      errors++;
      $display("FAIL y_saturate: got %h want f0", rd_addr);
    end
  endtask

  task automatic test_hold();
    pixel(224, 36);
    for (int h = 225; h <= 300; h++) pixel(h, 36);
    // Output shows pixel 299 (cell 2), stage 0 holds pixel 300 (cell 2, sub 16).
    for (int i = 0; i < 100; i++) begin
      @(negedge masterclk);
      hCount = 10'(224 + i);
      vCount = 10'(36 + i);
    end
    checks++;
    if (hCount_o !== 10'd299 || vCount_o !== 10'd36 || x_coord !== 4'd2 || y_coord !== 4'd0 ||
        cell_apparent !== 5'd3 || in_grid !== 1'b1 || rd_addr !== 8'h02) begin
      errors++;
      $display("FAIL hold_outputs: got h=%0d v=%0d x=%0d y=%0d c=%h g=%b a=%h want h=299 v=36 x=2 y=0 c=03 g=1 a=02",
               hCount_o, vCount_o, x_coord, y_coord, cell_apparent, in_grid, rd_addr);
    end
    for (int h = 301; h <= 313; h++) pixel(h, 36);
    checks++;
    if (rd_addr !== 8'h02 || hCount_o !== 10'd312) begin
      errors++;
      $display("FAIL hold_resume_313: got a=%h h=%0d want a=02 h=312", rd_addr, hCount_o);
    end
    pixel(314, 36);
    checks++;
    if (rd_addr !== 8'h03 || x_coord !== 4'd2) begin
      errors++;
      $display("FAIL hold_resume_314: got a=%h x=%0d want a=03 x=2", rd_addr, x_coord);
    end
  endtask

`ifdef CELL_SUB_OUT_EN
  task automatic test_sub_offsets();
    pixel(224, 36);
    for (int h = 225; h <= 254; h++) pixel(h, 36);
    checks++;
    if (x_sub_o !== 5'd29 || x_coord !== 4'd0 || y_sub_o !== 5'd0 || hCount_o !== 10'd253) begin
      errors++;
      $display("FAIL sub_253: got xs=%0d x=%0d ys=%0d h=%0d want xs=29 x=0 ys=0 h=253",
               x_sub_o, x_coord, y_sub_o, hCount_o);
    end
    pixel(255, 36);
    checks++;
    if (x_sub_o !== 5'd0 || x_coord !== 4'd1) begin
      errors++;
      $display("FAIL sub_254: got xs=%0d x=%0d want xs=0 x=1", x_sub_o, x_coord);
    end
    pixel(224, 37);
    pixel(225, 37);
    checks++;
    if (y_sub_o !== 5'd1 || x_sub_o !== 5'd0) begin
      errors++;
      $display("FAIL sub_row37: got ys=%0d xs=%0d want ys=1 xs=0", y_sub_o, x_sub_o);
    end
  endtask
`endif

  task automatic test_midframe_reset();
    @(negedge masterclk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rd_addr !== 8'h00 || hCount_o !== 10'd0 || vCount_o !== 10'd0 || x_coord !== 4'd0 ||
        y_coord !== 4'd0 || cell_apparent !== 5'd0 || in_grid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got a=%h h=%0d v=%0d x=%0d y=%0d c=%h g=%b want all zero",
               rd_addr, hCount_o, vCount_o, x_coord, y_coord, cell_apparent, in_grid);
    end
    @(negedge masterclk);
    rst_n = 1'b1;
    pixel(224, 200);
    pixel(225, 200);
    pixel(226, 200);
    checks++;
    if (in_grid !== 1'b0 || hCount_o !== 10'd225) begin
      errors++;
      $display("FAIL post_reset_unsynced: got g=%b h=%0d want g=0 h=225", in_grid, hCount_o);
    end
    pixel(224, 36);
    pixel(225, 36);
    checks++;
    if (in_grid !== 1'b1 || hCount_o !== 10'd224 || vCount_o !== 10'd36 || cell_apparent !== 5'd1) begin
      errors++;
      $display("FAIL post_reset_resync: got g=%b h=%0d v=%0d c=%h want g=1 h=224 v=36 c=01",
               in_grid, hCount_o, vCount_o, cell_apparent);
    end
  endtask

  initial begin
    test_reset();
    test_row36();
    test_row_advance();
    test_corner();
    test_hold();
`ifdef CELL_SUB_OUT_EN
    test_sub_offsets();
`endif
    test_midframe_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
